// File: rtl/short_stack_unit_pkg.sv
// Shared types and constants for the short-stack unit: command and restart
// packet layouts, the op encoding and the stored stack entry.
package short_stack_unit_pkg;

    localparam int NUM_RAYS = 512;
    localparam int RAY_W    = $clog2(NUM_RAYS);
    localparam int SS_DEPTH = 4;
    localparam int PTR_W    = $clog2(SS_DEPTH);
    localparam int NUM_W    = PTR_W + 1;
    localparam int NODE_W   = 16;
    localparam int TMAX_W   = 32;
    localparam int ADDR_W   = RAY_W + PTR_W;
    localparam logic [NODE_W-1:0] ROOT_ID = '0;

    typedef enum logic [1:0] {
        SS_PUSH   = 2'b00,
        SS_POP    = 2'b01,
        SS_UPDATE = 2'b10,
        SS_RSVD   = 2'b11
    } ss_op_e;

    typedef struct packed {
        logic [RAY_W-1:0]  ray_id;
        logic [PTR_W-1:0]  ss_wptr;
        logic [NUM_W-1:0]  ss_num;
        ss_op_e            op;
        logic [NODE_W-1:0] node_id;
        logic [TMAX_W-1:0] t_max;
    } trav_to_ss_t;

    typedef struct packed {
        logic [RAY_W-1:0]  ray_id;
        logic [PTR_W-1:0]  ss_wptr;
        logic [NUM_W-1:0]  ss_num;
        logic [NODE_W-1:0] node_id;
        logic [TMAX_W-1:0] t_max;
        logic              restart_root;
    } ss_to_tarb_t;

    typedef struct packed {
        logic [NODE_W-1:0] node_id;
        logic [TMAX_W-1:0] t_max;
    } ss_entry_t;

    // Slot holding the top of stack: one below the write pointer, wrapping.
    function automatic logic [PTR_W-1:0] top_slot(input logic [PTR_W-1:0] wptr);
        return wptr - PTR_W'(1);
    endfunction

endpackage

// File: rtl/ss_out_fifo.sv
// Two-entry output FIFO toward the traversal arbiter. Handshake: a packet
// moves when out_valid=1 and out_stall=0; out_valid/out_data hold while
// stalled. The producer must not write when full (the parent's stall rule
// guarantees this); a write into a full FIFO is ignored.
module ss_out_fifo
    import short_stack_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  ss_to_tarb_t in_data,
    output logic        out_valid,
    output ss_to_tarb_t out_data,
    input  logic        out_stall,
    output logic [1:0]  count
);

    ss_to_tarb_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  cnt;
    logic        do_push;
    logic        do_pop;

    assign do_push   = in_valid && (cnt != 2'd2);
    assign do_pop    = (cnt != 2'd0) && !out_stall;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign count     = cnt;

    // Storage, pointers and occupancy; reset clears contents so data reads zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/short_stack_unit.sv
// Short-stack responder: executes PUSH/POP/UPDATE against per-ray stacks held
// in an inferred dual-port RAM addressed by {ray_id, slot}. Each POP yields
// one restart packet two cycles after acceptance.
// Optional macro SHORT_STACK_STATS_EN adds saturating 32-bit command counters.
// Handshake (both channels): transfer when valid=1 and stall=0; the sender
// holds valid and data stable while stall=1.
module short_stack_unit
    import short_stack_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trav_to_ss_valid,
    input  trav_to_ss_t trav_to_ss_data,
    output logic        trav_to_ss_stall,
    output logic        ss_to_tarb_valid,
    output ss_to_tarb_t ss_to_tarb_data,
    input  logic        ss_to_tarb_stall
`ifdef SHORT_STACK_STATS_EN
    ,
    output logic [31:0] stat_push,
    output logic [31:0] stat_pop,
    output logic [31:0] stat_restart,
    output logic [31:0] stat_overflow
`endif
);

    // Stage 0: command decode and RAM access
    logic              accept;
    logic              cmd_empty;
    logic [PTR_W-1:0]  cmd_top;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              node_we;
    logic              tmax_we;
    logic              pop_acc;

    assign accept    = rst && trav_to_ss_valid && !trav_to_ss_stall;
    assign cmd_empty = (trav_to_ss_data.ss_num == '0);
    assign cmd_top   = top_slot(trav_to_ss_data.ss_wptr);
    assign rd_addr   = {trav_to_ss_data.ray_id, cmd_top};
    assign wr_addr   = (trav_to_ss_data.op == SS_PUSH)
                     ? {trav_to_ss_data.ray_id, trav_to_ss_data.ss_wptr} : rd_addr;
    assign node_we   = accept && (trav_to_ss_data.op == SS_PUSH);
    assign tmax_we   = accept && ((trav_to_ss_data.op == SS_PUSH) ||
                                  ((trav_to_ss_data.op == SS_UPDATE) && !cmd_empty));
    assign pop_acc   = accept && (trav_to_ss_data.op == SS_POP);

    // Separate node/t_max arrays let UPDATE rewrite t_max without a read.
    logic [NODE_W-1:0] node_ram [NUM_RAYS*SS_DEPTH];
    logic [TMAX_W-1:0] tmax_ram [NUM_RAYS*SS_DEPTH];
    ss_entry_t         rd_entry;

    // Stack RAM: one write port, one registered read port; never reset.
    always_ff @(posedge clk) begin
        if (node_we) node_ram[wr_addr] <= trav_to_ss_data.node_id;
        if (tmax_we) tmax_ram[wr_addr] <= trav_to_ss_data.t_max;
        if (pop_acc) rd_entry <= '{node_id: node_ram[rd_addr], t_max: tmax_ram[rd_addr]};
    end

    // Stage 1: POP context alongside the RAM read data
    logic              s1_valid;
    logic              s1_root;
    logic [RAY_W-1:0]  s1_ray;
    logic [PTR_W-1:0]  s1_wptr;
    logic [PTR_W-1:0]  s1_slot;
    logic [NUM_W-1:0]  s1_num;
    logic [TMAX_W-1:0] s1_tmax;

    // Stage-1 valid; cleared by reset so in-flight POPs are dropped.
    always_ff @(posedge clk) begin
        if (!rst) s1_valid <= 1'b0;
        else      s1_valid <= pop_acc;
    end

    // Stage-1 POP context, captured only when a POP is accepted.
    always_ff @(posedge clk) begin
        if (pop_acc) begin
            s1_root <= cmd_empty;
            s1_ray  <= trav_to_ss_data.ray_id;
            s1_wptr <= trav_to_ss_data.ss_wptr;
            s1_slot <= cmd_top;
            s1_num  <= trav_to_ss_data.ss_num;
            s1_tmax <= trav_to_ss_data.t_max;
        end
    end

    // A write landing on the slot being popped this cycle wins (write-first).
    logic        fwd_node;
    logic        fwd_tmax;
    ss_to_tarb_t s1_pkt;

    assign fwd_node = node_we && (wr_addr == {s1_ray, s1_slot});
    assign fwd_tmax = tmax_we && (wr_addr == {s1_ray, s1_slot});

    // Assemble the restart packet: root restart or popped entry.
    always_comb begin
        s1_pkt        = '0;
        s1_pkt.ray_id = s1_ray;
        if (s1_root) begin
            s1_pkt.ss_wptr      = s1_wptr;
            s1_pkt.ss_num       = s1_num;
            s1_pkt.node_id      = ROOT_ID;
            s1_pkt.t_max        = s1_tmax;
            s1_pkt.restart_root = 1'b1;
        end else begin
            s1_pkt.ss_wptr      = s1_slot;
            s1_pkt.ss_num       = s1_num - NUM_W'(1);
            s1_pkt.node_id      = fwd_node ? trav_to_ss_data.node_id : rd_entry.node_id;
            s1_pkt.t_max        = fwd_tmax ? trav_to_ss_data.t_max : rd_entry.t_max;
            s1_pkt.restart_root = 1'b0;
        end
    end

    // Stage 2: output FIFO
    logic [1:0] fifo_count;

    ss_out_fifo u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_data   (s1_pkt),
        .out_valid (ss_to_tarb_valid),
        .out_data  (ss_to_tarb_data),
        .out_stall (ss_to_tarb_stall),
        .count     (fifo_count)
    );

    // Reserve FIFO room for every POP still in flight; independent of valid.
    logic [2:0] occupancy;
    assign occupancy        = 3'(fifo_count) + 3'(s1_valid);
    assign trav_to_ss_stall = (occupancy >= 3'd2);

`ifdef SHORT_STACK_STATS_EN
    logic is_push;
    logic is_pop;
    assign is_push = node_we;
    assign is_pop  = pop_acc;

    // Saturating counters of accepted commands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_push     <= '0;
            stat_pop      <= '0;
            stat_restart  <= '0;
            stat_overflow <= '0;
        end else begin
            if (is_push && (stat_push != '1)) stat_push <= stat_push + 32'd1;
            if (is_pop && (stat_pop != '1))   stat_pop  <= stat_pop + 32'd1;
            if (is_pop && cmd_empty && (stat_restart != '1))
                stat_restart <= stat_restart + 32'd1;
            if (is_push && (trav_to_ss_data.ss_num == NUM_W'(SS_DEPTH)) &&
                (stat_overflow != '1))
                stat_overflow <= stat_overflow + 32'd1;
        end
    end
`endif

endmodule

// File: doc/short_stack_unit.md
Name: short_stack_unit

Overview:
- Responder end of the traversal to short-stack channel. It executes PUSH, POP and UPDATE commands issued by trav_unit against per-ray short stacks.
- Entries live in on-chip RAM indexed by {rayID, slot}. Stack pointer state (ss_wptr, ss_num) travels with the ray and is supplied in each command, so the block holds no per-ray pointer state.
- Each POP produces one restart packet toward the traversal arbiter (tarb): either the popped node, or a root restart when the stack is empty.

Parameters:
- NUM_RAYS, 512, rays tracked; RAY_W = $clog2(NUM_RAYS).
- SS_DEPTH, 4, entries per ray stack (power of 2); PTR_W = $clog2(SS_DEPTH).
- NODE_W, 16, nodeID width.
- ROOT_ID, 0, nodeID emitted on an empty-stack restart.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- trav_to_ss_valid  in  1  command valid
- trav_to_ss_data  in  trav_to_ss_t  {rayID, ss_wptr[PTR_W], ss_num[PTR_W+1], op[2], nodeID, t_max[32]}
- trav_to_ss_stall  out  1  back-pressure to trav
- ss_to_tarb_valid  out  1  restart packet valid
- ss_to_tarb_data  out  ss_to_tarb_t  {rayID, ss_wptr, ss_num, nodeID, t_max, restart_root}
- ss_to_tarb_stall  in  1  back-pressure from tarb

Behaviour:
- Reset (rst==0 at a clk edge): ss_to_tarb_valid=0, trav_to_stall=0, ss_to_tarb_data=0, output FIFO and pipeline emptied. Stack RAM is not cleared.
- Reset mid-operation: in-flight POPs are discarded and no packet is emitted. A PUSH or UPDATE already written is kept.
- Handshake: a transfer occurs when valid=1 and stall=0.
  - Valid is held and data is stable while stall=1.
  - trav_to_ss_stall is a combinational function of the output FIFO occupancy plus POPs in flight only. It never depends on trav_to_ss_valid.
- op encoding: 2'b00 PUSH, 2'b01 POP, 2'b10 UPDATE, 2'b11 reserved.
  - A reserved op is accepted and dropped. It has no side effects.
- PUSH
  - Write {nodeID, t_max} to slot ss_wptr of rayID.
  - No output packet.
  - Overflow (ss_num==SS_DEPTH) still writes, overwriting the oldest entry circularly. Pointer bookkeeping belongs to trav.
- POP
  - If ss_num==0: emit packet with nodeID=ROOT_ID, restart_root=1, t_max=command t_max, ss_wptr and ss_num unchanged. The RAM is not read.
  - Otherwise: read slot (ss_wptr-1) mod SS_DEPTH, with wrap from 0 to SS_DEPTH-1. Emit stored nodeID and t_max, restart_root=0, ss_wptr=ss_wptr-1 mod SS_DEPTH, ss_num=ss_num-1.
- UPDATE
  - If ss_num>0: overwrite only the t_max of slot (ss_wptr-1) mod SS_DEPTH.
  - If ss_num==0: drop.
  - No output packet in either case.
- Pipeline
  - Stage 0: accept the command and issue the RAM read/write.
  - Stage 1: RAM data is valid.
  - Stage 2: write into the 2-entry output FIFO.
  - Latency from POP accept to ss_to_tarb_valid is 2 cycles with no stall. Empty-stack POPs use the same latency.
- Hazards
  - A PUSH or UPDATE to the same {rayID, slot} that a POP in stage 1 is reading forwards the write data into that POP's result (write-first).
  - A PUSH followed by a POP of the same ray on the next cycle returns the pushed entry.
- Stall rule: stall=1 when (FIFO count + POPs in stages 1..2) >= 2. This guarantees no loss under a continuous ss_to_tarb_stall.
- Throughput: one command per cycle when not stalled.

Optional Feature:
- SHORT_STACK_STATS_EN defined: adds outputs stat_push, stat_pop, stat_restart and stat_overflow, each 32 bits.
  - Each counter increments on the corresponding accepted command. A restart is a POP with ss_num==0; an overflow is a PUSH with ss_num==SS_DEPTH.
  - Counters saturate at all-ones and clear on reset.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package holds: trav_to_ss_t, ss_to_tarb_t, ss_op_e (PUSH/POP/UPDATE), ss_entry_t {nodeID, t_max}, and constants SS_DEPTH and NUM_RAYS.
- One sub-module: ss_out_fifo, a 2-entry valid/stall FIFO.
- The RAM is an inferred simple dual-port array inside short_stack_unit.

Test Plan:
- PUSH ray 6 {node 12, t_max 5.0} at wptr 0, then POP with wptr 1, num 1 -> packet 2 cycles later: node 12, t_max 0x40A00000, wptr 0, num 0, restart_root=0.
- POP ray 3 with num 0, t_max 4.0 -> node ROOT_ID, restart_root=1, wptr and num unchanged.
- PUSH nodes 1..5 to ray 4, wrapping wptr 0..3,0 with num capped at 4 by the bench. POP with wptr 1, num 4 -> node 5; POP with wptr 0, num 3 -> node 4 (slot 3, wrap).
- PUSH ray 5 {node 7, t_max 10.0}, UPDATE t_max 2.5, POP -> node 7, t_max 0x40200000. UPDATE with num 0 -> no effect and no packet.
- Hold ss_to_tarb_stall=1 while issuing 4 POPs -> trav_to_ss_stall asserts after 2. After release, all 4 packets emerge in order with no loss or duplication.
- Assert rst low with 2 POPs in flight -> ss_to_tarb_valid=0 the next cycle and neither packet is ever emitted.
